sad_min_reducer: RTL and testbench
==================================

# sad_min_reducer

Parametrised sequential minimum-SAD reducer for the multi-core motion-estimation array. It collects one (SAD, row, column) result per core channel, each arriving with its own valid strobe at any time. It then scans the captured results one channel per cycle, applying the per-channel row offset, and publishes the global minimum with a one-cycle Done pulse. It replaces the fixed 8-input combinational comparator tree plus SAD register that sits between the cores and the display driver.

## Interface
Parameters:
- NUM_CH, 8: number of core channels; must be ≥ 2.
- SAD_W, 32: SAD value width.
- COORD_W, 8: row and column width.
- ROW_STRIDE, 8: row offset added per channel index.

Ports:
- Clk  in  1  sole clock; all logic is rising-edge.
- Rst  in  1  synchronous, active-low reset.
- Start  in  1  begins a round; honoured only in IDLE.
- InValid  in  NUM_CH  per-channel result strobe.
- InSAD  in  NUM_CH*SAD_W  packed SADs; channel i occupies [i*SAD_W +: SAD_W].
- InRow  in  NUM_CH*COORD_W  packed local rows.
- InCol  in  NUM_CH*COORD_W  packed columns.
- Captured  out  NUM_CH  per-channel captured mask.
- Busy  out  1  high in COLLECT, SCAN and DONE.
- Done  out  1  one-cycle completion pulse.
- MinSAD  out  SAD_W  winning SAD.
- MinRow  out  COORD_W  winning global row.
- MinCol  out  COORD_W  winning column.

## Operation
- The FSM has four states: IDLE, COLLECT, SCAN, DONE.
- IDLE → COLLECT on Start=1. Captured clears on that edge.
- In COLLECT, a channel with InValid[i]=1 and Captured[i]=0 latches its SAD, row and column into holding register i and sets Captured[i]. Further strobes on an already-captured channel are ignored, so the first result wins.
- COLLECT → SCAN on the edge where Captured, including the strobes captured on that same edge, becomes all ones. Several channels may strobe in the same cycle.
- In SCAN, a 0..NUM_CH-1 index visits one channel per cycle.
  - Channel 0 loads the running minimum unconditionally.
  - Channel i>0 replaces the running minimum only if its SAD is strictly less than the running SAD. Ties therefore resolve to the lowest channel index.
- Global row = local row + i*ROW_STRIDE, truncated to COORD_W bits (wraps modulo 2^COORD_W). SAD comparison is unsigned.
- SCAN → DONE after channel NUM_CH-1 is compared. MinSAD, MinRow and MinCol load from the running minimum on that edge.
- DONE → IDLE unconditionally after one cycle.
- Outputs hold their values until the next DONE or reset.
- Start outside IDLE is ignored. InValid outside COLLECT is ignored.
- Reset at any point forces IDLE and aborts the round with no Done. On reset:
  - Captured = 0, Busy = 0, Done = 0.
  - MinSAD = all ones; MinRow = 0; MinCol = 0.
  - Holding registers and the running minimum are don't-care.

## Timing
- Start sampled high in IDLE: Busy=1 from the next cycle.
- A strobe is captured on the same edge it is sampled. Captured[i] is visible the following cycle.
- Let E be the edge of the last capture. SCAN occupies the cycles after edges E … E+NUM_CH-1. Outputs update at edge E+NUM_CH. Done is high for exactly the cycle after E+NUM_CH.
- Minimum round length (all strobes in the Start-following cycle) = 1 + 1 + NUM_CH + 1 cycles from Start to Done.
- Start may be asserted in the cycle Done is high; it is ignored. The earliest accepted Start is the cycle after Done, when the block is back in IDLE.
- There is no combinational path from inputs to outputs.

## Configuration
- SADMIN_INDEX_EN defined: adds the output port MinCh (width $clog2(NUM_CH)).
  - Holds the winning channel index.
  - Loads alongside MinSAD; resets to 0.
- SADMIN_INDEX_EN undefined: port and register are absent. All other behaviour is identical.

## Structure
- Shared package sad_pkg holds:
  - state encodings IDLE=2'd0, COLLECT=2'd1, SCAN=2'd2, DONE=2'd3;
  - the all-ones SAD reset constant;
  - the lane-slicing helper.
- One sub-module, sad_min_cmp, is combinational. Inputs: current candidate SAD/row/col, channel index, running minimum, first-flag. Output: next running minimum (and index when enabled), with the offset add and strict-less compare.
- The top level holds the FSM, holding registers, Captured mask and output registers.

## Test plan
- Defaults, all 8 strobes together in the cycle after Start, SADs 90,80,70,60,50,40,30,20, rows all 1, cols 0..7 → Done 10 cycles after Start; MinSAD=20, MinRow=57, MinCol=7.
- Channels 2 and 5 both SAD=5, others 100 → MinSAD=5, MinRow=local+16, MinCol from channel 2; MinCh=2 when SADMIN_INDEX_EN is defined.
- Staggered strobes over 20 cycles, channel 3 strobed twice (SAD 10 then 1) → first value kept (MinSAD reflects 10 if it is the minimum); Done exactly 8 cycles after the final new capture.
- Channel 7 local row 250 wins with ROW_STRIDE=8 → MinRow=(250+56) mod 256=50.
- Rst low during SCAN → next cycle Busy=0, Captured=0, MinSAD=all ones, no Done; a subsequent Start runs a clean round.
- InValid pulses in IDLE and Start during SCAN → no capture, no restart; the round completes with unchanged timing.

Source files
------------

// File: rtl/sad_min_reducer_pkg.sv
// Shared state encoding, SAD reset constant and lane-slicing helper for sad_min_reducer.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Widest supported SAD; instances slice off the low SAD_W bits.
    localparam logic [63:0] SAD_INIT = '1;

    function automatic int laneLsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sad_min_reducer_cmp.sv
// Combinational scan step: applies the per-channel row offset and keeps the strictly smaller SAD.
// Optional winning-index path is enabled by SADMIN_INDEX_EN.
module sad_min_cmp #(
    parameter int SAD_W      = 32,
    parameter int COORD_W    = 8,
    parameter int ROW_STRIDE = 8,
    parameter int IDX_W      = 3
) (
    input  logic [SAD_W-1:0]   candSad_i,
    input  logic [COORD_W-1:0] candRow_i,
    input  logic [COORD_W-1:0] candCol_i,
    input  logic [IDX_W-1:0]   chIdx_i,
    input  logic [SAD_W-1:0]   runSad_i,
    input  logic [COORD_W-1:0] runRow_i,
    input  logic [COORD_W-1:0] runCol_i,
    input  logic               first_i,
`ifdef SADMIN_INDEX_EN
    input  logic [IDX_W-1:0]   runIdx_i,
    output logic [IDX_W-1:0]   nextIdx_o,
`endif
    output logic [SAD_W-1:0]   nextSad_o,
    output logic [COORD_W-1:0] nextRow_o,
    output logic [COORD_W-1:0] nextCol_o
);

    logic [COORD_W-1:0] globalRow;
    logic               take;

    // Truncating before the multiply gives the same result modulo 2^COORD_W.
    assign globalRow = candRow_i + COORD_W'(chIdx_i) * COORD_W'(ROW_STRIDE);
    assign take      = first_i || (candSad_i < runSad_i);

    always_comb begin
        nextSad_o = runSad_i;
        nextRow_o = runRow_i;
        nextCol_o = runCol_i;
`ifdef SADMIN_INDEX_EN
        nextIdx_o = runIdx_i;
`endif
        if (take) begin
            nextSad_o = candSad_i;
            nextRow_o = globalRow;
            nextCol_o = candCol_i;
`ifdef SADMIN_INDEX_EN
            nextIdx_o = chIdx_i;
`endif
        end
    end

endmodule

// File: rtl/sad_min_reducer.sv
// Sequential minimum-SAD reducer: collect one result per channel, scan one channel per cycle, pulse Done.
// Defining SADMIN_INDEX_EN adds the MinCh winning-channel output.
module sad_min_reducer
    import sad_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int SAD_W      = 32,
    parameter int COORD_W    = 8,
    parameter int ROW_STRIDE = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic [NUM_CH-1:0]           InValid,
    input  logic [NUM_CH*SAD_W-1:0]     InSAD,
    input  logic [NUM_CH*COORD_W-1:0]   InRow,
    input  logic [NUM_CH*COORD_W-1:0]   InCol,
    output logic [NUM_CH-1:0]           Captured,
    output logic                        Busy,
    output logic                        Done,
    output logic [SAD_W-1:0]            MinSAD,
    output logic [COORD_W-1:0]          MinRow,
    output logic [COORD_W-1:0]          MinCol
`ifdef SADMIN_INDEX_EN
    ,
    output logic [$clog2(NUM_CH)-1:0]   MinCh
`endif
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_e             state_q, state_d;
    logic [NUM_CH-1:0]  captured_q, captured_d;
    logic [NUM_CH-1:0]  newCapture;
    logic [IDX_W-1:0]   scanIdx_q, scanIdx_d;
    logic               scanLast;

    logic [SAD_W-1:0]   laneSad [NUM_CH];
    logic [COORD_W-1:0] laneRow [NUM_CH];
    logic [COORD_W-1:0] laneCol [NUM_CH];

    logic [SAD_W-1:0]   holdSad_q [NUM_CH];
    logic [COORD_W-1:0] holdRow_q [NUM_CH];
    logic [COORD_W-1:0] holdCol_q [NUM_CH];

    logic [SAD_W-1:0]   runSad_q, nextSad;
    logic [COORD_W-1:0] runRow_q, nextRow;
    logic [COORD_W-1:0] runCol_q, nextCol;

    logic [SAD_W-1:0]   minSad_q;
    logic [COORD_W-1:0] minRow_q;
    logic [COORD_W-1:0] minCol_q;

`ifdef SADMIN_INDEX_EN
    logic [IDX_W-1:0]   runIdx_q, nextIdx, minIdx_q;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : gLane
        assign laneSad[g] = InSAD[laneLsb(g, SAD_W) +: SAD_W];
        assign laneRow[g] = InRow[laneLsb(g, COORD_W) +: COORD_W];
        assign laneCol[g] = InCol[laneLsb(g, COORD_W) +: COORD_W];
    end

    // Only the first strobe per channel within COLLECT is taken.
    assign newCapture = (state_q == COLLECT) ? (InValid & ~captured_q) : '0;
    assign scanLast   = (state_q == SCAN) && (scanIdx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        scanIdx_d  = scanIdx_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d    = COLLECT;
                    captured_d = '0;
                end
            end
            COLLECT: begin
                captured_d = captured_q | newCapture;
                if (&captured_d) begin
                    state_d   = SCAN;
                    scanIdx_d = '0;
                end
            end
            SCAN: begin
                if (scanIdx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    scanIdx_d = scanIdx_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    sad_min_cmp #(
        .SAD_W      (SAD_W),
        .COORD_W    (COORD_W),
        .ROW_STRIDE (ROW_STRIDE),
        .IDX_W      (IDX_W)
    ) u_cmp (
        .candSad_i (holdSad_q[scanIdx_q]),
        .candRow_i (holdRow_q[scanIdx_q]),
        .candCol_i (holdCol_q[scanIdx_q]),
        .chIdx_i   (scanIdx_q),
        .runSad_i  (runSad_q),
        .runRow_i  (runRow_q),
        .runCol_i  (runCol_q),
        .first_i   (scanIdx_q == '0),
`ifdef SADMIN_INDEX_EN
        .runIdx_i  (runIdx_q),
        .nextIdx_o (nextIdx),
`endif
        .nextSad_o (nextSad),
        .nextRow_o (nextRow),
        .nextCol_o (nextCol)
    );

    // Holding registers and running minimum carry no reset; they are rewritten every round.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (newCapture[i]) begin
                holdSad_q[i] <= laneSad[i];
                holdRow_q[i] <= laneRow[i];
                holdCol_q[i] <= laneCol[i];
            end
        end
        if (state_q == SCAN) begin
            runSad_q <= nextSad;
            runRow_q <= nextRow;
            runCol_q <= nextCol;
`ifdef SADMIN_INDEX_EN
            runIdx_q <= nextIdx;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= IDLE;
            captured_q <= '0;
            scanIdx_q  <= '0;
            minSad_q   <= SAD_INIT[SAD_W-1:0];
            minRow_q   <= '0;
            minCol_q   <= '0;
`ifdef SADMIN_INDEX_EN
            minIdx_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            scanIdx_q  <= scanIdx_d;
            if (scanLast) begin
                minSad_q <= nextSad;
                minRow_q <= nextRow;
                minCol_q <= nextCol;
`ifdef SADMIN_INDEX_EN
                minIdx_q <= nextIdx;
`endif
            end
        end
    end

    assign Captured = captured_q;
    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);
    assign MinSAD   = minSad_q;
    assign MinRow   = minRow_q;
    assign MinCol   = minCol_q;
`ifdef SADMIN_INDEX_EN
    assign MinCh    = minIdx_q;
`endif

endmodule

// File: tb/tb_sad_min_reducer.sv
// Scoreboard bench for sad_min_reducer: rounds push expected minima, a Done monitor pops and compares.
// Covers the SADMIN_INDEX_EN MinCh output when that macro is defined.
module tb_sad_min_reducer;

    localparam int NUM_CH     = 8;
    localparam int SAD_W      = 32;
    localparam int COORD_W    = 8;
    localparam int ROW_STRIDE = 8;

    logic                      Clk = 1'b0;
    logic                      Rst = 1'b0;
    logic                      Start = 1'b0;
    logic [NUM_CH-1:0]         InValid = '0;
    logic [NUM_CH*SAD_W-1:0]   InSAD = '0;
    logic [NUM_CH*COORD_W-1:0] InRow = '0;
    logic [NUM_CH*COORD_W-1:0] InCol = '0;
    logic [NUM_CH-1:0]         Captured;
    logic                      Busy;
    logic                      Done;
    logic [SAD_W-1:0]          MinSAD;
    logic [COORD_W-1:0]        MinRow;
    logic [COORD_W-1:0]        MinCol;
`ifdef SADMIN_INDEX_EN
    logic [$clog2(NUM_CH)-1:0] MinCh;
`endif

    sad_min_reducer #(
        .NUM_CH     (NUM_CH),
        .SAD_W      (SAD_W),
        .COORD_W    (COORD_W),
        .ROW_STRIDE (ROW_STRIDE)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .InValid  (InValid),
        .InSAD    (InSAD),
        .InRow    (InRow),
        .InCol    (InCol),
        .Captured (Captured),
        .Busy     (Busy),
        .Done     (Done),
        .MinSAD   (MinSAD),
        .MinRow   (MinRow),
        .MinCol   (MinCol)
`ifdef SADMIN_INDEX_EN
        ,
        .MinCh    (MinCh)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [SAD_W-1:0]   sad;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        int                 ch;
        int                 cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t lastExp;
    exp_t monE;
    int   errors = 0;
    int   checks = 0;
    logic [NUM_CH-1:0] expCaptured = '0;

    // Round description: first strobe offset and values, optional later duplicate strobe.
    int                 strobeAt [NUM_CH];
    int                 dupAt    [NUM_CH];
    logic [SAD_W-1:0]   fSad [NUM_CH];
    logic [COORD_W-1:0] fRow [NUM_CH];
    logic [COORD_W-1:0] fCol [NUM_CH];
    logic [SAD_W-1:0]   dSad [NUM_CH];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic setLane(input int ch, input logic [SAD_W-1:0] sad, input logic [COORD_W-1:0] row,
                           input logic [COORD_W-1:0] col);
        InSAD[ch*SAD_W +: SAD_W]       = sad;
        InRow[ch*COORD_W +: COORD_W]   = row;
        InCol[ch*COORD_W +: COORD_W]   = col;
    endtask

    // Reference: first value per channel wins; lowest SAD with ties to lowest index; row offset mod 2^COORD_W.
    task automatic modelPush(input int startCyc);
        exp_t e;
        int   lastCap;
        int   winRow;
        e.sad   = fSad[0];
        e.col   = fCol[0];
        e.ch    = 0;
        winRow  = int'(fRow[0]);
        lastCap = strobeAt[0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (fSad[i] < e.sad) begin
                e.sad  = fSad[i];
                e.col  = fCol[i];
                e.ch   = i;
                winRow = int'(fRow[i]);
            end
            if (strobeAt[i] > lastCap) lastCap = strobeAt[i];
        end
        e.row   = COORD_W'((winRow + e.ch * ROW_STRIDE) % (1 << COORD_W));
        e.cyc   = startCyc + lastCap + 9;
        lastExp = e;
        expQ.push_back(e);
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got 1, want 0 at cycle %0d", cyc);
            end else begin
                monE = expQ.pop_front();
                checkOutput("done_cycle", 64'(cyc), 64'(monE.cyc));
                checkOutput("min_sad", 64'(MinSAD), 64'(monE.sad));
                checkOutput("min_row", 64'(MinRow), 64'(monE.row));
                checkOutput("min_col", 64'(MinCol), 64'(monE.col));
                checkOutput("busy_in_done", 64'(Busy), 64'(1));
`ifdef SADMIN_INDEX_EN
                checkOutput("min_ch", 64'(MinCh), 64'(monE.ch));
`endif
            end
        end
    end

    task automatic waitDone();
        int n = 0;
        while (expQ.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no Done, want Done within 200 cycles");
            expQ.delete();
        end
    endtask

    task automatic applyStimulus(input bit idlePulse, input bit startInScan);
        int s;
        int last = 0;
        int span = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (strobeAt[i] > last) last = strobeAt[i];
            if (strobeAt[i] > span) span = strobeAt[i];
            if (dupAt[i] > span) span = dupAt[i];
        end
        if (idlePulse) begin
            InValid = '1;
            for (int i = 0; i < NUM_CH; i++) setLane(i, 32'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            tick();
            InValid = '0;
            checkOutput("idle_strobe_busy", 64'(Busy), 64'(0));
            checkOutput("idle_strobe_captured", 64'(Captured), 64'(expCaptured));
        end
        Start = 1'b1;
        s = cyc;
        modelPush(s);
        tick();
        Start = 1'b0;
        checkOutput("busy_after_start", 64'(Busy), 64'(1));
        checkOutput("captured_cleared", 64'(Captured), 64'(0));
        for (int off = 1; off <= span; off++) begin
            InValid = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (strobeAt[i] == off) begin
                    InValid[i] = 1'b1;
                    setLane(i, fSad[i], fRow[i], fCol[i]);
                end else if (dupAt[i] == off) begin
                    InValid[i] = 1'b1;
                    setLane(i, dSad[i], 8'($urandom), 8'($urandom));
                end else begin
                    setLane(i, $urandom, 8'($urandom), 8'($urandom));
                end
            end
            tick();
        end
        InValid = '0;
        if (startInScan) begin
            while (cyc < s + last + 3) tick();
            Start   = 1'b1;
            InValid = '1;
            for (int i = 0; i < NUM_CH; i++) setLane(i, 32'd0, 8'($urandom), 8'($urandom));
            tick();
            Start   = 1'b0;
            InValid = '0;
        end
        waitDone();
        expCaptured = '1;
        tick();
        checkOutput("hold_sad", 64'(MinSAD), 64'(lastExp.sad));
        checkOutput("hold_done_low", 64'(Done), 64'(0));
    endtask

    task automatic clearRound();
        for (int i = 0; i < NUM_CH; i++) begin
            strobeAt[i] = 1;
            dupAt[i]    = 0;
            fSad[i]     = 32'd100;
            fRow[i]     = 8'($urandom);
            fCol[i]     = 8'($urandom);
            dSad[i]     = 32'd0;
        end
    endtask

    initial begin
        Rst = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", 64'(Busy), 64'(0));
        checkOutput("reset_done", 64'(Done), 64'(0));
        checkOutput("reset_captured", 64'(Captured), 64'(0));
        checkOutput("reset_min_sad", 64'(MinSAD), 64'(32'hFFFF_FFFF));
        checkOutput("reset_min_row", 64'(MinRow), 64'(0));
        checkOutput("reset_min_col", 64'(MinCol), 64'(0));
        Rst = 1'b1;
        tick();

        // Descending SADs, all strobes together right after Start.
        clearRound();
        for (int i = 0; i < NUM_CH; i++) begin
            fSad[i] = 32'(90 - 10 * i);
            fRow[i] = 8'd1;
            fCol[i] = 8'(i);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1_row57", 64'(MinRow), 64'(57));

        // Tie between channels 2 and 5 resolves to channel 2.
        clearRound();
        fSad[2] = 32'd5;
        fSad[5] = 32'd5;
        applyStimulus(1'b0, 1'b0);

        // Staggered strobes; channel 3 strobed again with a smaller SAD that must be ignored.
        clearRound();
        strobeAt = '{1, 4, 7, 2, 10, 13, 16, 20};
        for (int i = 0; i < NUM_CH; i++) fSad[i] = 32'(50 + i);
        fSad[3]  = 32'd10;
        dupAt[3] = 5;
        dSad[3]  = 32'd1;
        applyStimulus(1'b0, 1'b0);

        // Row offset wraps: channel 7 local row 250.
        clearRound();
        fSad[7] = 32'd3;
        fRow[7] = 8'd250;
        applyStimulus(1'b0, 1'b0);
        checkOutput("wrap_row50", 64'(MinRow), 64'(50));

        // Reset during SCAN aborts the round without Done.
        clearRound();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        InValid = '1;
        for (int i = 0; i < NUM_CH; i++) setLane(i, 32'd7, 8'd1, 8'd1);
        tick();
        InValid = '0;
        tick();
        tick();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        checkOutput("abort_busy", 64'(Busy), 64'(0));
        checkOutput("abort_captured", 64'(Captured), 64'(0));
        checkOutput("abort_min_sad", 64'(MinSAD), 64'(32'hFFFF_FFFF));
        checkOutput("abort_done", 64'(Done), 64'(0));
        expCaptured = '0;
        repeat (15) tick();
        clearRound();
        fSad[4] = 32'd9;
        applyStimulus(1'b0, 1'b0);

        // Idle strobes and a Start during SCAN are both ignored.
        clearRound();
        fSad[6] = 32'd2;
        applyStimulus(1'b1, 1'b1);

        // Randomised rounds with small SAD ranges to provoke ties and duplicates.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                strobeAt[i] = int'($urandom_range(1, 6));
                fSad[i]     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
                fRow[i]     = 8'($urandom);
                fCol[i]     = 8'($urandom);
                dupAt[i]    = ($urandom_range(0, 3) == 0) ? strobeAt[i] + int'($urandom_range(1, 3)) : 0;
                dSad[i]     = 32'($urandom_range(0, 3));
            end
            applyStimulus(r[0], r[1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
